// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the RV32I-subset multicycle CPU: FSM states, ALU control codes,
// opcodes and datapath mux selects used by the controller, ALU and datapath.
package cpu_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_ALU_WB   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_TRAP     = 4'd10
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_REG   = 2'b10;

    localparam logic [1:0] SRC_B_REG    = 2'b00;
    localparam logic [1:0] SRC_B_IMM    = 2'b01;
    localparam logic [1:0] SRC_B_CONST4 = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    localparam logic PC_SRC_ALU    = 1'b0;
    localparam logic PC_SRC_ALUOUT = 1'b1;

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU operation decode for R-type and I-type arithmetic instructions,
// flagging funct combinations the CPU does not implement.
module alu_decoder
    import cpu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [2:0] alu_ctrl,
    output logic       illegal_funct
);

    always_comb begin
        alu_ctrl      = ALU_ADD;
        illegal_funct = 1'b0;
        if (opcode == OP_R) begin
            case (funct3)
                F3_ADD:  alu_ctrl = funct7_5 ? ALU_SUB : ALU_ADD;
                F3_AND:  alu_ctrl = ALU_AND;
                F3_OR:   alu_ctrl = ALU_OR;
                F3_SLT:  alu_ctrl = ALU_SLT;
                default: illegal_funct = 1'b1;
            endcase
        end else if (opcode == OP_I) begin
            // funct7 carries immediate bits here, so it never selects sub
            case (funct3)
                F3_ADD:  alu_ctrl = ALU_ADD;
                F3_AND:  alu_ctrl = ALU_AND;
                F3_OR:   alu_ctrl = ALU_OR;
                F3_SLT:  alu_ctrl = ALU_SLT;
                default: illegal_funct = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the RV32I-subset CPU: sequences fetch/decode/execute/writeback,
// drives the ALU and operand muxes, and handshakes with a variable-latency memory.
module multicycle_ctrl
    import cpu_pkg::*;
#(
    parameter state_t RESET_STATE = S_FETCH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        eq,
    input  logic        mem_ready,
    output logic [2:0]  alu_ctrl,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  imm_src,
    output logic [1:0]  result_src,
    output logic        pc_src,
    output logic        pc_we,
    output logic        ir_we,
    output logic        reg_we,
    output logic        mem_re,
    output logic        mem_we,
    output logic        retire,
    output logic        illegal,
    output logic [3:0]  state
);

    state_t     state_q;
    state_t     state_d;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [2:0] dec_alu_ctrl;
    logic       dec_illegal;
    logic       unused_instr_bits;

    assign opcode            = instr[6:0];
    assign funct3            = instr[14:12];
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};
    assign state             = state_q;

    alu_decoder u_alu_decoder (
        .opcode        (opcode),
        .funct3        (funct3),
        .funct7_5      (instr[30]),
        .alu_ctrl      (dec_alu_ctrl),
        .illegal_funct (dec_illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        alu_ctrl   = ALU_ADD;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_REG;
        imm_src    = IMM_I;
        result_src = RES_ALUOUT;
        pc_src     = PC_SRC_ALU;
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        retire     = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_re     = 1'b1;
                alu_src_a  = SRC_A_PC;
                alu_src_b  = SRC_B_CONST4;
                result_src = RES_ALU;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                // Branch target is computed speculatively and parked in ALUOUT
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
                imm_src   = IMM_B;
                case (opcode)
                    OP_R:      state_d = S_EXEC_R;
                    OP_I:      state_d = S_EXEC_I;
                    OP_LOAD:   state_d = (funct3 == F3_WORD) ? S_MEM_ADDR : S_TRAP;
                    OP_STORE:  state_d = (funct3 == F3_WORD) ? S_MEM_ADDR : S_TRAP;
                    OP_BRANCH: state_d = (funct3 == F3_BEQ || funct3 == F3_BNE)
                                         ? S_BRANCH : S_TRAP;
                    default:   state_d = S_TRAP;
                endcase
            end

            S_EXEC_R: begin
                alu_src_a = SRC_A_REG;
                alu_src_b = SRC_B_REG;
                alu_ctrl  = dec_alu_ctrl;
                state_d   = dec_illegal ? S_TRAP : S_ALU_WB;
            end

            S_EXEC_I: begin
                alu_src_a = SRC_A_REG;
                alu_src_b = SRC_B_IMM;
                imm_src   = IMM_I;
                alu_ctrl  = dec_alu_ctrl;
                state_d   = dec_illegal ? S_TRAP : S_ALU_WB;
            end

            S_ALU_WB: begin
                reg_we     = 1'b1;
                result_src = RES_ALUOUT;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end

            S_MEM_ADDR: begin
                alu_src_a = SRC_A_REG;
                alu_src_b = SRC_B_IMM;
                imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
                state_d   = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            end

            S_MEM_RD: begin
                mem_re     = 1'b1;
                result_src = RES_ALUOUT;
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end
            end

            S_MEM_WB: begin
                reg_we     = 1'b1;
                result_src = RES_MEMDATA;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end

            S_MEM_WR: begin
                mem_we     = 1'b1;
                result_src = RES_ALUOUT;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end

            S_BRANCH: begin
                alu_src_a = SRC_A_REG;
                alu_src_b = SRC_B_REG;
                alu_ctrl  = ALU_SUB;
                pc_src    = PC_SRC_ALUOUT;
                pc_we     = funct3[0] ? ~eq : eq;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end

            S_TRAP: begin
                illegal = 1'b1;
            end

            default: begin
                state_d = S_TRAP;
            end
        endcase

        // FETCH is a Mealy/Moore source of strobes; reset must silence them immediately
        if (rst) begin
            pc_we   = 1'b0;
            ir_we   = 1'b0;
            reg_we  = 1'b0;
            mem_re  = 1'b0;
            mem_we  = 1'b0;
            retire  = 1'b0;
            illegal = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl: per-instruction sequences, memory stalls,
// branch outcomes, traps and asynchronous reset.
module tb_multicycle_ctrl;
    import cpu_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        eq;
    logic        mem_ready;
    logic [2:0]  alu_ctrl;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  imm_src;
    logic [1:0]  result_src;
    logic        pc_src;
    logic        pc_we;
    logic        ir_we;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
    logic        retire;
    logic        illegal;
    logic [3:0]  state;

    int tests = 0;
    int fails = 0;

    multicycle_ctrl #(.RESET_STATE(S_FETCH)) dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .eq         (eq),
        .mem_ready  (mem_ready),
        .alu_ctrl   (alu_ctrl),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .imm_src    (imm_src),
        .result_src (result_src),
        .pc_src     (pc_src),
        .pc_we      (pc_we),
        .ir_we      (ir_we),
        .reg_we     (reg_we),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .retire     (retire),
        .illegal    (illegal),
        .state      (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_ready = 1'b1; instr = 32'h0; eq = 1'b0;
        #2;
        tests++; if (state !== 4'd0) begin fails++; $display("FAIL reset_state: got %0d expected 0", state); end
        tests++; if ({pc_we, ir_we, reg_we, mem_re, mem_we, retire, illegal} !== 7'b0) begin
            fails++; $display("FAIL reset_strobes: got %b expected 0000000", {pc_we, ir_we, reg_we, mem_re, mem_we, retire, illegal}); end
        tick();
        tests++; if (state !== 4'd0 || mem_re !== 1'b0) begin fails++; $display("FAIL reset_held: got state %0d mem_re %b expected 0/0", state, mem_re); end
        rst = 1'b0;
    endtask

    task automatic test_add();
        instr = 32'h002081B3; mem_ready = 1'b1;
        #1;
        tests++; if ({state, ir_we, pc_we, mem_re, alu_src_b, result_src} !== {4'd0, 3'b111, 2'b10, 2'b10}) begin
            fails++; $display("FAIL add_fetch: got %h expected %h", {state, ir_we, pc_we, mem_re, alu_src_b, result_src}, {4'd0, 3'b111, 2'b10, 2'b10}); end
        tick();
        tests++; if ({state, alu_src_a, alu_src_b, imm_src} !== {4'd1, 2'b01, 2'b01, 2'b10}) begin
            fails++; $display("FAIL add_decode: got %h expected %h", {state, alu_src_a, alu_src_b, imm_src}, {4'd1, 2'b01, 2'b01, 2'b10}); end
        tick();
        tests++; if ({state, alu_ctrl, alu_src_a, alu_src_b} !== {4'd2, 3'b000, 2'b10, 2'b00}) begin
            fails++; $display("FAIL add_exec_r: got %h expected %h", {state, alu_ctrl, alu_src_a, alu_src_b}, {4'd2, 3'b000, 2'b10, 2'b00}); end
        tick();
        tests++; if ({state, reg_we, retire, result_src, mem_we} !== {4'd4, 2'b11, 2'b00, 1'b0}) begin
            fails++; $display("FAIL add_alu_wb: got %h expected %h", {state, reg_we, retire, result_src, mem_we}, {4'd4, 2'b11, 2'b00, 1'b0}); end
        tick();
        tests++; if (state !== 4'd0 || retire !== 1'b0) begin fails++; $display("FAIL add_latency: got state %0d retire %b expected 0/0", state, retire); end
    endtask

    task automatic test_sub_slti();
        instr = 32'h402081B3; mem_ready = 1'b1;
        tick(); tick();
        tests++; if ({state, alu_ctrl} !== {4'd2, 3'b001}) begin fails++; $display("FAIL sub_exec_r: got %h expected %h", {state, alu_ctrl}, {4'd2, 3'b001}); end
        tick(); tick();
        instr = 32'h0020A193;
        tick(); tick();
        tests++; if ({state, alu_ctrl, alu_src_a, alu_src_b, imm_src} !== {4'd3, 3'b101, 2'b10, 2'b01, 2'b00}) begin
            fails++; $display("FAIL slti_exec_i: got %h expected %h", {state, alu_ctrl, alu_src_a, alu_src_b, imm_src}, {4'd3, 3'b101, 2'b10, 2'b01, 2'b00}); end
        tick();
        tests++; if ({state, reg_we, retire} !== {4'd4, 2'b11}) begin fails++; $display("FAIL slti_wb: got %h expected %h", {state, reg_we, retire}, {4'd4, 2'b11}); end
        tick();
        tests++; if (state !== 4'd0) begin fails++; $display("FAIL slti_latency: got %0d expected 0", state); end
    endtask

    task automatic test_lw_stall();
        int n = 0, rd_seen = 0, re_cnt = 0, ret_cnt = 0, wb_res = 0, clash = 0;
        instr = 32'h0000A183;
        while (n < 20) begin
            mem_ready = (state == S_MEM_RD && rd_seen < 3) ? 1'b0 : 1'b1;
            if (state == S_MEM_RD) rd_seen++;
            #1;
            if (state == S_MEM_RD && mem_re) re_cnt++;
            if (retire) ret_cnt++;
            if (state == S_MEM_WB && result_src == 2'b01 && reg_we) wb_res++;
            if ((reg_we && mem_we) || (mem_re && mem_we)) clash++;
            tick();
            n++;
            if (state == S_FETCH) break;
        end
        tests++; if (n !== 8) begin fails++; $display("FAIL lw_latency: got %0d expected 8", n); end
        tests++; if (re_cnt !== 4) begin fails++; $display("FAIL lw_mem_re_cycles: got %0d expected 4", re_cnt); end
        tests++; if (ret_cnt !== 1) begin fails++; $display("FAIL lw_retire_count: got %0d expected 1", ret_cnt); end
        tests++; if (wb_res !== 1) begin fails++; $display("FAIL lw_mem_wb: got %0d expected 1", wb_res); end
        tests++; if (clash !== 0) begin fails++; $display("FAIL lw_strobe_clash: got %0d expected 0", clash); end
        mem_ready = 1'b1;
    endtask

    task automatic test_bne();
        for (int k = 0; k < 2; k++) begin
            int n = 0;
            logic br_pc_we = 1'bx;
            logic br_pc_src = 1'bx;
            logic br_ret = 1'bx;
            instr = 32'h00209463; mem_ready = 1'b1; eq = (k == 0);
            while (n < 20) begin
                #1;
                if (state == S_BRANCH) begin
                    br_pc_we = pc_we; br_pc_src = pc_src; br_ret = retire;
                    tests++; if (alu_ctrl !== 3'b001) begin fails++; $display("FAIL bne_alu_sub: got %b expected 001", alu_ctrl); end
                end
                tick();
                n++;
                if (state == S_FETCH) break;
            end
            tests++; if (n !== 3) begin fails++; $display("FAIL bne_latency_%0d: got %0d expected 3", k, n); end
            tests++; if (br_pc_we !== (k == 0 ? 1'b0 : 1'b1)) begin fails++; $display("FAIL bne_pc_we_eq%0d: got %b expected %b", 1 - k, br_pc_we, (k == 0 ? 1'b0 : 1'b1)); end
            tests++; if ({br_pc_src, br_ret} !== 2'b11) begin fails++; $display("FAIL bne_pc_src_retire_%0d: got %b expected 11", k, {br_pc_src, br_ret}); end
        end
        eq = 1'b0;
    endtask

    task automatic test_illegal();
        int bad = 0;
        instr = 32'h0000007F; mem_ready = 1'b1;
        tick(); tick();
        tests++; if ({state, illegal} !== {4'd10, 1'b1}) begin fails++; $display("FAIL trap_entry: got %h expected %h", {state, illegal}, {4'd10, 1'b1}); end
        for (int c = 0; c < 12; c++) begin
            mem_ready = c[0];
            #1;
            if (state !== S_TRAP || illegal !== 1'b1 ||
                {pc_we, ir_we, reg_we, mem_re, mem_we, retire} !== 6'b0) bad++;
            tick();
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL trap_absorbing: got %0d bad cycles expected 0", bad); end
        rst = 1'b1;
        #1;
        tests++; if ({state, illegal} !== {4'd0, 1'b0}) begin fails++; $display("FAIL trap_reset: got %h expected %h", {state, illegal}, {4'd0, 1'b0}); end
        tick();
        rst = 1'b0; mem_ready = 1'b1;
        instr = 32'h002091B3;
        tick(); tick();
        tests++; if ({state, alu_src_a} !== {4'd2, 2'b10}) begin fails++; $display("FAIL badfunct_exec_r: got %h expected %h", {state, alu_src_a}, {4'd2, 2'b10}); end
        tick();
        tests++; if ({state, illegal, reg_we, retire} !== {4'd10, 3'b100}) begin
            fails++; $display("FAIL badfunct_trap: got %h expected %h", {state, illegal, reg_we, retire}, {4'd10, 3'b100}); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_sw_async_reset();
        instr = 32'h0020A023; mem_ready = 1'b1;
        tick(); tick();
        tests++; if ({state, imm_src, alu_src_b} !== {4'd5, 2'b01, 2'b01}) begin fails++; $display("FAIL sw_mem_addr: got %h expected %h", {state, imm_src, alu_src_b}, {4'd5, 2'b01, 2'b01}); end
        mem_ready = 1'b0;
        tick();
        tests++; if ({state, mem_we, mem_re, reg_we, retire} !== {4'd8, 4'b1000}) begin
            fails++; $display("FAIL sw_mem_wr: got %h expected %h", {state, mem_we, mem_re, reg_we, retire}, {4'd8, 4'b1000}); end
        tick();
        tests++; if ({state, mem_we} !== {4'd8, 1'b1}) begin fails++; $display("FAIL sw_hold: got %h expected %h", {state, mem_we}, {4'd8, 1'b1}); end
        #2;
        rst = 1'b1;
        #1;
        tests++; if ({state, mem_we, mem_re, retire} !== {4'd0, 3'b000}) begin
            fails++; $display("FAIL sw_async_reset: got %h expected %h", {state, mem_we, mem_re, retire}, {4'd0, 3'b000}); end
        tick();
        rst = 1'b0; mem_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        int n = 0, ret_cnt = 0, we_cnt = 0, clash = 0;
        instr = 32'h0020A023; mem_ready = 1'b1;
        while (n < 20) begin
            #1;
            if (retire) ret_cnt++;
            if (mem_we) we_cnt++;
            if ((reg_we && mem_we) || (mem_re && mem_we)) clash++;
            tick();
            n++;
            if (state == S_FETCH) break;
        end
        tests++; if ({n, ret_cnt, we_cnt, clash} !== {32'd4, 32'd1, 32'd1, 32'd0}) begin
            fails++; $display("FAIL sw_fast: got n=%0d ret=%0d we=%0d clash=%0d expected 4/1/1/0", n, ret_cnt, we_cnt, clash); end
        mem_ready = 1'b0;
        #1;
        tests++; if ({state, ir_we, pc_we, mem_re} !== {4'd0, 3'b001}) begin fails++; $display("FAIL fetch_stall: got %h expected %h", {state, ir_we, pc_we, mem_re}, {4'd0, 3'b001}); end
        tick();
        tests++; if (state !== 4'd0) begin fails++; $display("FAIL fetch_stall_hold: got %0d expected 0", state); end
        mem_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_slti();
        test_lw_stall();
        test_bne();
        test_illegal();
        test_sw_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle control FSM for the RV32I-subset CPU datapath.
- Sits at the opposite end of the ALU interface from the ALU: it drives ALUctrl and the operand muxes, and consumes the ALU EQ flag for branches.
- It also sequences the IR, PC, register-file and memory enables, and handshakes with a variable-latency unified memory.

Parameters:
- RESET_STATE, S_FETCH, state entered on reset (fixed; exposed for bench visibility only).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- instr  in  32  instruction register contents; stable from DECODE until the next ir_we
- eq  in  1  ALU EQ flag (SUM==0), valid in the same cycle
- mem_ready  in  1  memory completes the current read/write this cycle
- alu_ctrl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- alu_src_a  out  2  00 PC, 01 OLDPC, 10 REG
- alu_src_b  out  2  00 REG, 01 IMM, 10 CONST4
- imm_src  out  2  00 I-type, 01 S-type, 10 B-type
- result_src  out  2  00 ALUOUT reg, 01 MEMDATA, 10 ALU result
- pc_src  out  1  0 ALU result, 1 ALUOUT reg
- pc_we, ir_we, reg_we, mem_re, mem_we  out  1 each  write/read strobes
- retire  out  1  one-cycle pulse when an instruction completes
- illegal  out  1  sticky trap flag
- state  out  4  current state encoding, for debug

Behaviour:
- Reset: while rst=1, state=FETCH and all strobes, retire and illegal are 0. This is asynchronous. Reset mid-instruction abandons the instruction and takes no further writes.
- Outputs are Moore decodes of state, except these Mealy terms:
  - pc_we/ir_we in FETCH are gated by mem_ready.
  - pc_we in BRANCH depends on eq.
  - retire depends on mem_ready where noted below.
- FETCH: mem_re=1, alu_src_a=PC, alu_src_b=CONST4, alu_ctrl=add, result_src=ALU result, pc_src=0.
  - If mem_ready: ir_we=1, pc_we=1, go to DECODE.
  - Otherwise hold FETCH with no writes.
- DECODE: alu_src_a=OLDPC, alu_src_b=IMM, imm_src=B, alu_ctrl=add; the branch target is latched into ALUOUT. Next state by opcode instr[6:0]:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 with funct3=010 -> MEM_ADDR (lw)
  - 0100011 with funct3=010 -> MEM_ADDR (sw)
  - 1100011 with funct3 000/001 -> BRANCH
  - anything else -> TRAP
- EXEC_R: alu_src_a=REG, alu_src_b=REG. alu_ctrl from funct3/funct7[5]:
  - 000/0 add; 000/1 sub; 111 and; 110 or; 010 slt.
  - Any other combination -> TRAP instead of ALU_WB.
- EXEC_I: alu_src_a=REG, alu_src_b=IMM, imm_src=I.
  - funct3 000 add, 111 and, 110 or, 010 slt; others -> TRAP.
  - funct7 is ignored.
  - Goes to ALU_WB.
- ALU_WB: reg_we=1, result_src=ALUOUT, retire=1, go to FETCH.
- MEM_ADDR: alu_src_a=REG, alu_src_b=IMM, imm_src=I for lw / S for sw, alu_ctrl=add. Goes to MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_re=1, result_src=ALUOUT as address. Hold until mem_ready, then MEM_WB.
- MEM_WB: reg_we=1, result_src=MEMDATA, retire=1, go to FETCH.
- MEM_WR: mem_we=1 held every cycle until mem_ready. On mem_ready: retire=1, go to FETCH.
- BRANCH: alu_src_a=REG, alu_src_b=REG, alu_ctrl=sub, pc_src=1.
  - pc_we = eq for funct3=000 (beq), ~eq for 001 (bne).
  - retire=1, go to FETCH.
- TRAP: illegal=1, all strobes 0, retire 0. Absorbing until rst.
- Latency with mem_ready tied high (cycles):
  - R/I: 4
  - lw: 5
  - sw: 4
  - branch: 3
  - Each mem_ready=0 cycle adds one.
- Never assert reg_we and mem_we in the same cycle.
- Never assert mem_re and mem_we together.

Decomposition:
- Package cpu_pkg holds:
  - state enum
  - alu_ctrl codes (ALU_ADD … ALU_SLT)
  - opcode constants
  - src_a/src_b/imm_src/result_src encodings
- These are shared with the ALU and datapath muxes.
- One sub-module, alu_decoder: combinational funct3/funct7/opcode -> alu_ctrl plus an illegal-funct flag. The FSM instantiates it.

Test Plan:
- add x3,x1,x2 (0x002081B3), mem_ready=1: states FETCH, DECODE, EXEC_R, ALU_WB. EXEC_R has alu_ctrl=000. ALU_WB has reg_we=1 and retire=1. 4 cycles total.
- sub (0x402081B3) then slti (0x0020A193): EXEC_R alu_ctrl=001; EXEC_I alu_ctrl=101, alu_src_b=01.
- lw (0x0000A183) with mem_ready low 3 cycles in MEM_RD: mem_re held 4 cycles, MEM_WB has result_src=01. retire exactly once, 8 cycles total.
- bne (0x00209463): eq=1 gives pc_we=0 in BRANCH; eq=0 gives pc_we=1 with pc_src=1. Both take 3 cycles.
- Illegal opcode 0x0000007F: DECODE goes to TRAP, illegal=1 held 10+ cycles with no strobes. Asserting rst then returns to FETCH with illegal=0.
- Async reset asserted mid-MEM_WR (no clock edge): mem_we drops immediately, state=FETCH, no retire.
